// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared decode constants and enums for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  F7_MULDIV  = 7'b0000001;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit with ID/EX stall
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [31:0]      instr_ex,
    input  logic [WIDTH-1:0] rs1_data_ex,
    input  logic [WIDTH-1:0] rs2_data_ex,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e state, state_nxt;
    md_op_e    op_dec, op_q;

    logic [WIDTH-1:0] acc, lo, opb, result_q;
    logic             a_neg, b_neg;
    logic [CW-1:0]    count;

    logic             is_m, sgn_a, sgn_b, a_in_neg, b_in_neg;
    logic             div_zero, div_ovf, special;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0] quo_c, rem_c, corrected;
    logic             unused_instr;

    assign unused_instr = ^{instr_ex[24:15], instr_ex[11:7]};

    assign is_m   = (instr_ex[6:0] == OPC_OP) && (instr_ex[31:25] == F7_MULDIV);
    assign op_dec = md_op_e'(instr_ex[14:12]);

    // Operand signedness and magnitudes; results are computed on magnitudes and sign-corrected in DONE
    always_comb begin
        sgn_a    = (op_dec == MD_MULH) || (op_dec == MD_MULHSU) || (op_dec == MD_DIV) || (op_dec == MD_REM);
        sgn_b    = (op_dec == MD_MULH) || (op_dec == MD_DIV) || (op_dec == MD_REM);
        a_in_neg = sgn_a & rs1_data_ex[WIDTH-1];
        b_in_neg = sgn_b & rs2_data_ex[WIDTH-1];
        mag_a    = a_in_neg ? -rs1_data_ex : rs1_data_ex;
        mag_b    = b_in_neg ? -rs2_data_ex : rs2_data_ex;
        div_zero = instr_ex[14] && (rs2_data_ex == '0);
        div_ovf  = ((op_dec == MD_DIV) || (op_dec == MD_REM)) &&
                   (rs1_data_ex == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_data_ex == '1);
        special  = div_zero | div_ovf;
    end

    // One shift-add step (multiply) or one restoring step (divide)
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ok    = ~div_diff[WIDTH];
    end

    // Sign correction and result selection from the final accumulator contents
    always_comb begin
        prod_c    = (a_neg ^ b_neg) ? -{acc, lo} : {acc, lo};
        quo_c     = (a_neg ^ b_neg) ? -lo : lo;
        rem_c     = a_neg ? -acc : acc;
        corrected = '0;
        case (op_q)
            MD_MUL:                        corrected = prod_c[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  corrected = prod_c[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:               corrected = quo_c;
            default:                       corrected = rem_c;
        endcase
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (is_m) state_nxt = special ? S_DONE : S_BUSY;
            S_BUSY: if (count == CW'(WIDTH - 1)) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, iteration datapath and held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= MD_MUL;
            acc      <= '0;
            lo       <= '0;
            opb      <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            count    <= '0;
            result_q <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: if (is_m) begin
                    op_q  <= op_dec;
                    count <= '0;
                    opb   <= mag_b;
                    if (special) begin
                        // Preload quotient/remainder so the DONE path yields the fixed answer
                        a_neg <= 1'b0;
                        b_neg <= 1'b0;
                        acc   <= div_zero ? rs1_data_ex : '0;
                        lo    <= div_zero ? '1 : rs1_data_ex;
                    end else begin
                        a_neg <= a_in_neg;
                        b_neg <= b_in_neg;
                        acc   <= '0;
                        lo    <= mag_a;
                    end
                end
                S_BUSY: begin
                    count <= count + 1'b1;
                    if (op_q[2]) begin
                        acc <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        lo  <= {lo[WIDTH-2:0], div_ok};
                    end else begin
                        {acc, lo} <= {mul_sum, lo[WIDTH-1:1]};
                    end
                end
                default: result_q <= corrected;
            endcase
        end
    end

    assign stall        = ((state == S_BUSY) || ((state == S_IDLE) && is_m)) && !flush;
    assign result_valid = (state == S_DONE) && !flush;
    assign result       = result_valid ? corrected : result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] instr_ex = NOP;
    logic [31:0] rs1_data_ex = '0;
    logic [31:0] rs2_data_ex = '0;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;
    logic [31:0] sb[$];

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .instr_ex(instr_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .stall(stall), .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_instr(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb_); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0)) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
    endfunction

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int stall_cnt;
        bit got;
        logic [31:0] want;
        @(posedge clk); #1;
        instr_ex = m_instr(f3);
        rs1_data_ex = a;
        rs2_data_ex = b;
        sb.push_back(exp);
        cyc = 0; stall_cnt = 0; got = 0;
        @(negedge clk);
        total++;
        if (stall !== 1'b1) $display("FAIL %s_stall_c0: got %b expected 1", name, stall);
        else passed++;
        while (!got && cyc < 100) begin
            if (cyc != 0) @(negedge clk);
            if (result_valid === 1'b1) begin
                got = 1;
                total++;
                if (sb.size() == 0) $display("FAIL %s_sb_empty: got valid with no expected entry", name);
                else begin
                    want = sb.pop_front();
                    if (result !== want) $display("FAIL %s_result: got %h expected %h", name, result, want);
                    else passed++;
                end
                total++;
                if (cyc !== lat) $display("FAIL %s_latency: got %0d expected %0d", name, cyc, lat);
                else passed++;
                total++;
                if (stall !== 1'b0) $display("FAIL %s_stall_done: got %b expected 0", name, stall);
                else passed++;
            end else begin
                if (stall === 1'b1) stall_cnt++;
                cyc++;
            end
        end
        total++;
        if (!got) $display("FAIL %s_timeout: got no result_valid expected within 100 cycles", name);
        else passed++;
        total++;
        if (stall_cnt !== lat) $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, lat);
        else passed++;
    endtask

    task automatic idle_cycle(input string name, input logic [31:0] held);
        @(posedge clk); #1;
        instr_ex = NOP;
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || stall !== 1'b0)
            $display("FAIL %s_idle: got valid=%b stall=%b expected 0/0", name, result_valid, stall);
        else passed++;
        total++;
        if (result !== held) $display("FAIL %s_held: got %h expected %h", name, result, held);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0)
            $display("FAIL reset_outputs: got stall=%b valid=%b result=%h expected 0/0/0", stall, result_valid, result);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle("reset_release", 32'h0);
    endtask

    task automatic test_mul();
        do_op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        idle_cycle("mul", 32'hFFFFFFEB);
    endtask

    task automatic test_mulh();
        do_op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        idle_cycle("mulh", 32'h00000000);
    endtask

    task automatic test_back_to_back();
        do_op("div", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
        do_op("rem_b2b", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
        idle_cycle("b2b", 32'hFFFFFFFF);
    endtask

    task automatic test_flush();
        bit seen;
        @(posedge clk); #1;
        instr_ex = m_instr(3'd4);
        rs1_data_ex = 32'd100;
        rs2_data_ex = 32'd7;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL flush_c10: got stall=%b valid=%b expected 0/0", stall, result_valid);
        else passed++;
        @(posedge clk); #1;
        flush = 1'b0;
        instr_ex = NOP;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1 || stall === 1'b1) seen = 1;
        end
        total++;
        if (seen) $display("FAIL flush_quiet: got valid/stall activity expected none");
        else passed++;
        total++;
        if (result !== 32'hFFFFFFFF) $display("FAIL flush_held: got %h expected ffffffff", result);
        else passed++;
        // flush landing on the DONE cycle of a special-case divide
        @(posedge clk); #1;
        instr_ex = m_instr(3'd5);
        rs1_data_ex = 32'd5;
        rs2_data_ex = 32'd0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || result !== 32'hFFFFFFFF)
            $display("FAIL flush_done: got valid=%b result=%h expected 0/ffffffff", result_valid, result);
        else passed++;
        @(posedge clk); #1;
        flush = 1'b0;
        instr_ex = NOP;
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0 || result !== 32'hFFFFFFFF)
            $display("FAIL flush_done_after: got valid=%b result=%h expected 0/ffffffff", result_valid, result);
        else passed++;
    endtask

    task automatic test_special();
        do_op("divu_zero", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        do_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        do_op("rem_zero", 3'd6, 32'hFFFFFFF3, 32'd0, 32'hFFFFFFF3, 1);
        idle_cycle("special", 32'hFFFFFFF3);
    endtask

    task automatic test_random();
        logic [31:0] a, b, e;
        logic [2:0] f3;
        for (int i = 0; i < 8; i++) begin
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : (i == 5) ? 32'd3 : $urandom;
            f3 = 3'($urandom_range(0, 7));
            if (i == 6) f3 = 3'd2;
            if (i == 7) f3 = 3'd7;
            e  = ref_model(f3, a, b);
            do_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, e, ref_lat(f3, a, b));
        end
        idle_cycle("rand", e);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        instr_ex = m_instr(3'd0);
        rs1_data_ex = 32'd9;
        rs2_data_ex = 32'd9;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        instr_ex = NOP;
        #1;
        total++;
        if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 32'h0)
            $display("FAIL async_reset: got stall=%b valid=%b result=%h expected 0/0/0", stall, result_valid, result);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        instr_ex = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (stall !== 1'b0 || result_valid !== 1'b0)
                $display("FAIL add_idle%0d: got stall=%b valid=%b expected 0/0", i, stall, result_valid);
            else passed++;
        end
        do_op("mul_after_rst", 3'd0, 32'd9, 32'd9, 32'd81, 33);
        idle_cycle("mul_after_rst", 32'd81);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_back_to_back();
        test_flush();
        test_special();
        test_random();
        test_async_reset();
        total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
